// File: rtl/joypad_scan_sequencer.sv
// Serial joypad scan sequencer: drives latch/pulse on the pad shift register,
// shifts in eight button bits, debounces them and publishes a stable P1-ordered vector.
module joypad_scan_sequencer #(
  parameter int LATCH_CYCLES   = 396,
  parameter int HALF_CYCLES    = 198,
  parameter int SCAN_PERIOD    = 550000,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       I_CLK,
  input  logic       I_RESET_L,
  input  logic       I_SCAN_EN,
  input  logic       I_SCAN_REQ,
  input  logic       I_PAD_DATA,
  output logic       O_LATCH,
  output logic       O_PULSE,
  output logic [7:0] O_BUTTONS,
  output logic       O_SCAN_DONE,
  output logic       O_PRESS_EVENT,
  output logic       O_BUSY
);

  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TMR_W  = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SCAN_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_MAX     = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_READ, S_PULSE_HI, S_DONE} state_t;

  state_t            state;
  logic [PH_W-1:0]   ph_cnt;
  logic [2:0]        idx;
  logic [TMR_W-1:0]  tmr;
  logic              pending;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic [7:0]        raw;
  logic [7:0]        last_raw;
  logic [7:0]        mapped;
  logic [7:0]        buttons_prev;
  logic              pad_sync_p0;
  logic              pad_sync_p1;
  logic              tmr_wrap;
  logic              start_req;

  // Serial order A,B,SELECT,START,UP,DOWN,LEFT,RIGHT -> P1 layout
  function automatic logic [7:0] map_serial(input logic [7:0] s);
    return {s[3], s[2], s[1], s[0], s[5], s[4], s[6], s[7]};
  endfunction

  function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
    return (v >= DB_MAX) ? DB_MAX : v + 1'b1;
  endfunction

  // Stage p0/p1: pad data synchronizer (idles high = released)
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      pad_sync_p0 <= 1'b1;
      pad_sync_p1 <= 1'b1;
    end else begin
      pad_sync_p0 <= I_PAD_DATA;
      pad_sync_p1 <= pad_sync_p0;
    end
  end

  assign tmr_wrap  = I_SCAN_EN && (tmr == TMR_LAST);
  assign start_req = I_SCAN_REQ | tmr_wrap;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      tmr <= '0;
    end else if (I_SCAN_EN) begin
      tmr <= tmr_wrap ? '0 : tmr + 1'b1;
    end
  end

  always_comb begin
    mapped     = map_serial(raw);
    db_cnt_nxt = (mapped == last_raw) ? sat_inc(db_cnt) : DB_W'(1);
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      db_cnt      <= '0;
      raw         <= '0;
      last_raw    <= '0;
      O_BUTTONS   <= '0;
      O_LATCH     <= 1'b0;
      O_PULSE     <= 1'b0;
      O_SCAN_DONE <= 1'b0;
      O_BUSY      <= 1'b0;
    end else begin
      O_SCAN_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            state   <= S_LATCH;
            O_LATCH <= 1'b1;
            O_BUSY  <= 1'b1;
            ph_cnt  <= '0;
            idx     <= '0;
          end
        end
        S_LATCH: begin
          if (start_req) pending <= 1'b1;
          if (ph_cnt == LATCH_LAST) begin
            state   <= S_READ;
            O_LATCH <= 1'b0;
            ph_cnt  <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (start_req) pending <= 1'b1;
          if (ph_cnt == HALF_LAST) begin
            raw[idx] <= ~pad_sync_p1;
            ph_cnt   <= '0;
            if (idx == 3'd7) begin
              state       <= S_DONE;
              O_SCAN_DONE <= 1'b1;
            end else begin
              state   <= S_PULSE_HI;
              O_PULSE <= 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_PULSE_HI: begin
          if (start_req) pending <= 1'b1;
          if (ph_cnt == HALF_LAST) begin
            state   <= S_READ;
            O_PULSE <= 1'b0;
            idx     <= idx + 1'b1;
            ph_cnt  <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // A mismatch restarts the count with the new vector; a match keeps it
          last_raw <= mapped;
          db_cnt   <= db_cnt_nxt;
          if (db_cnt_nxt == DB_MAX) O_BUTTONS <= mapped;
          pending <= 1'b0;
          if (pending || start_req) begin
            state   <= S_LATCH;
            O_LATCH <= 1'b1;
            ph_cnt  <= '0;
            idx     <= '0;
          end else begin
            state  <= S_IDLE;
            O_BUSY <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Rising-bit detector on the published vector; releases are ignored
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      buttons_prev  <= '0;
      O_PRESS_EVENT <= 1'b0;
    end else begin
      buttons_prev  <= O_BUTTONS;
      O_PRESS_EVENT <= |(O_BUTTONS & ~buttons_prev);
    end
  end

endmodule

// File: tb/tb_joypad_scan_sequencer.sv
// Directed bench for joypad_scan_sequencer: a DEBOUNCE_SCANS=2 instance and a
// DEBOUNCE_SCANS=1 instance, each fed by a behavioural NES pad shift register.
module tb_joypad_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, req0, data0, en1, req1, data1;
  logic       latch0, pulse0, done0, press0, busy0;
  logic       latch1, pulse1, done1, press1, busy1;
  logic [7:0] buttons0, buttons1;

  logic [7:0] pad0 = 8'h00, pad1 = 8'h00, sh0 = 8'h00, sh1 = 8'h00;
  logic       pq0 = 1'b0, pq1 = 1'b0, stuck0 = 1'b1;
  int         n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  joypad_scan_sequencer #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .SCAN_PERIOD(100), .DEBOUNCE_SCANS(2)) dut (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_SCAN_EN(en0), .I_SCAN_REQ(req0), .I_PAD_DATA(data0),
    .O_LATCH(latch0), .O_PULSE(pulse0), .O_BUTTONS(buttons0), .O_SCAN_DONE(done0),
    .O_PRESS_EVENT(press0), .O_BUSY(busy0));

  joypad_scan_sequencer #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .SCAN_PERIOD(100), .DEBOUNCE_SCANS(1)) dut1 (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_SCAN_EN(en1), .I_SCAN_REQ(req1), .I_PAD_DATA(data1),
    .O_LATCH(latch1), .O_PULSE(pulse1), .O_BUTTONS(buttons1), .O_SCAN_DONE(done1),
    .O_PRESS_EVENT(press1), .O_BUSY(busy1));

  // Pad shift register: parallel load while latched, shift on pulse rising edge,
  // serial bit k set = button k pressed, output active-low.
  always @(posedge clk) begin
    if (latch0) sh0 <= pad0;
    else if (pulse0 && !pq0) sh0 <= {1'b0, sh0[7:1]};
    pq0 <= pulse0;
    if (latch1) sh1 <= pad1;
    else if (pulse1 && !pq1) sh1 <= {1'b0, sh1[7:1]};
    pq1 <= pulse1;
  end
  assign data0 = stuck0 ? 1'b1 : ~sh0[0];
  assign data1 = ~sh1[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while (((sel ? done1 : done0) !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    chk1("scan_done_seen", (n < 200), 1'b1);
  endtask

  task automatic scan(input bit sel);
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eb, ed, el, ep;
    rst_n = 1'b0; en0 = 1'b0; req0 = 1'b0; en1 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    chk1("rst_latch", latch0, 1'b0);
    chk1("rst_pulse", pulse0, 1'b0);
    chk ("rst_buttons", buttons0, 8'h00);
    chk1("rst_done", done0, 1'b0);
    chk1("rst_press", press0, 1'b0);
    chk1("rst_busy", busy0, 1'b0);
    chk ("rst_buttons1", buttons1, 8'h00);
    rst_n = 1'b1;
    tick();

    // Disconnected pad, full phase-by-phase timing of one scan
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      el = (c <= 4);
      ep = (c >= 5) && (c <= 49) && (((c - 5) / 3) % 2 == 1);
      chk1("s1_latch", latch0, el);
      chk1("s1_pulse", pulse0, ep);
      chk1("s1_busy", busy0, 1'b1);
      chk1("s1_done", done0, (c == 50));
      tick();
    end
    chk ("s1_buttons", buttons0, 8'h00);
    chk1("s1_idle", busy0, 1'b0);
    chk1("s1_press_a", press0, 1'b0);
    tick();
    chk1("s1_press_b", press0, 1'b0);

    // Alternating START / nothing never satisfies the debounce
    stuck0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pad0 = (i % 2 == 0) ? 8'h08 : 8'h00;
      scan(1'b0);
      tick();
      chk("s3_buttons", buttons0, 8'h00);
      tick();
      chk1("s3_press", press0, 1'b0);
    end

    // A held for two scans
    pad0 = 8'h01;
    scan(1'b0);
    tick();
    chk("s2_first", buttons0, 8'h00);
    scan(1'b0);
    tick();
    chk ("s2_second", buttons0, 8'h10);
    chk1("s2_press_early", press0, 1'b0);
    tick();
    chk1("s2_press", press0, 1'b1);
    tick();
    chk1("s2_press_one_cycle", press0, 1'b0);

    // Pending coalescing, back-to-back scans, timer wraps, enable dropped mid-scan
    en0 = 1'b1;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int c = 1; c <= 250; c++) begin
      eb = (c <= 150) || ((c >= 200) && (c <= 249));
      ed = (c == 50) || (c == 100) || (c == 150) || (c == 249);
      el = (c <= 4) || ((c >= 51) && (c <= 54)) || ((c >= 101) && (c <= 104)) || ((c >= 200) && (c <= 203));
      chk1("s4_busy", busy0, eb);
      chk1("s4_done", done0, ed);
      chk1("s4_latch", latch0, el);
      chk1("s4_press", press0, 1'b0);
      req0 = (c == 20) || (c == 60);
      if (c == 210) en0 = 1'b0;
      tick();
    end
    chk("s4_buttons", buttons0, 8'h10);

    // Reset during PULSE_HI
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (8) tick();
    chk1("s5_pulse_before", pulse0, 1'b1);
    chk ("s5_buttons_before", buttons0, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk1("s5_pulse", pulse0, 1'b0);
    chk1("s5_latch", latch0, 1'b0);
    chk1("s5_busy", busy0, 1'b0);
    chk ("s5_buttons", buttons0, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      chk1("s5_no_done", done0, 1'b0);
      chk1("s5_idle", busy0, 1'b0);
      tick();
    end

    // Single-scan debounce: RIGHT+UP, then RIGHT released
    pad1 = 8'h90;
    scan(1'b1);
    tick();
    chk("s6_first", buttons1, 8'h05);
    tick();
    chk1("s6_press", press1, 1'b1);
    pad1 = 8'h10;
    scan(1'b1);
    tick();
    chk ("s6_release", buttons1, 8'h04);
    chk1("s6_no_press_a", press1, 1'b0);
    tick();
    chk1("s6_no_press_b", press1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
